// File: rtl/i_norm_fixed_to_float_pkg.sv
// ============================================================================
// i_norm_fixed_to_float_pkg : shared constants and state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package i_norm_fixed_to_float_pkg;

  localparam int FLOAT_BIAS = 127;
  localparam int MANT_W     = 23;
  localparam int EXP_W      = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_NORM  = 3'd2;
  localparam logic [2:0] ST_ROUND = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Exponent of bit 31 of the magnitude before any normalising shift.
  function automatic logic [EXP_W-1:0] exp_init(input int frac_bits);
    return EXP_W'(31 + FLOAT_BIAS - frac_bits);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i_norm_fixed_to_float_normalizer.sv
// ============================================================================
// fixed_to_float_normalizer : magnitude shifter, exponent counter, RNE pack
// Rev 1.0
// ============================================================================
`default_nettype none

module fixed_to_float_normalizer
  import i_norm_fixed_to_float_pkg::*;
#(
  parameter int FRAC_BITS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic        shift_en,
  input  logic        round_en,
  input  logic [31:0] fixed_in,
  output logic        mag_zero,
  output logic        sh_msb,
  output logic [31:0] result
);

  localparam logic [EXP_W-1:0] EXP_INIT = exp_init(FRAC_BITS);

  logic              sign;
  logic [31:0]       sh;
  logic [EXP_W-1:0]  exp_cnt;
  logic [31:0]       mag;
  logic [MANT_W-1:0] mant;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic              mant_ovf;
  logic [MANT_W-1:0] mant_rnd;
  logic [EXP_W-1:0]  exp_rnd;

  // Two's-complement negate; 0x80000000 negates to itself, which is the
  // correct unsigned magnitude.
  assign mag      = fixed_in[31] ? (~fixed_in + 32'd1) : fixed_in;
  assign mag_zero = (mag == 32'd0);
  assign sh_msb   = sh[31];

  assign mant     = sh[30:8];
  assign guard    = sh[7];
  assign sticky   = |sh[6:0];
  assign round_up = guard & (sticky | mant[0]);
  assign mant_ovf = round_up & (&mant);
  assign mant_rnd = round_up ? (mant + 23'd1) : mant;
  assign exp_rnd  = exp_cnt + {{(EXP_W-1){1'b0}}, mant_ovf};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign    <= 1'b0;
      sh      <= 32'd0;
      exp_cnt <= '0;
      result  <= 32'd0;
    end else if (load_en) begin
      sign    <= fixed_in[31];
      sh      <= mag;
      exp_cnt <= EXP_INIT;
      if (mag_zero) begin
        result <= 32'd0;
      end
    end else if (shift_en) begin
      sh      <= {sh[30:0], 1'b0};
      exp_cnt <= exp_cnt - 8'd1;
    end else if (round_en) begin
      result <= {sign, exp_rnd, mant_rnd};
    end
  end

endmodule

`default_nettype wire

// File: rtl/i_norm_fixed_to_float.sv
// ============================================================================
// i_norm_fixed_to_float : Begin/ACK driven fixed-point to IEEE-754 converter
// Rev 1.0
// ============================================================================
`default_nettype none

module i_norm_fixed_to_float
  import i_norm_fixed_to_float_pkg::*;
#(
  parameter int FRAC_BITS = 26,
  parameter int W         = 32
) (
  input  logic         CLK,
  input  logic         RST_FF,
  input  logic         Begin_FSM_FF,
  input  logic [W-1:0] FIXED,
  output logic         ACK_FF,
  output logic [31:0]  RESULT
);

  logic [2:0]   state;
  logic [2:0]   state_nxt;
  logic [W-1:0] fixed_q;
  logic         mag_zero;
  logic         sh_msb;
  logic         load_en;
  logic         shift_en;
  logic         round_en;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (Begin_FSM_FF) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = mag_zero ? ST_DONE : ST_NORM;
      ST_NORM:  if (sh_msb) state_nxt = ST_ROUND;
      ST_ROUND: state_nxt = ST_DONE;
      ST_DONE:  if (!Begin_FSM_FF) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST_FF) begin
    if (RST_FF) begin
      state   <= ST_IDLE;
      fixed_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && Begin_FSM_FF) begin
        fixed_q <= FIXED;
      end
    end
  end

  assign load_en  = (state == ST_LOAD);
  assign shift_en = (state == ST_NORM) && !sh_msb;
  assign round_en = (state == ST_ROUND);
  assign ACK_FF   = (state == ST_DONE);

  fixed_to_float_normalizer #(
    .FRAC_BITS (FRAC_BITS)
  ) u_norm (
    .clk      (CLK),
    .rst      (RST_FF),
    .load_en  (load_en),
    .shift_en (shift_en),
    .round_en (round_en),
    .fixed_in (fixed_q),
    .mag_zero (mag_zero),
    .sh_msb   (sh_msb),
    .result   (RESULT)
  );

endmodule

`default_nettype wire

// File: tb/tb_i_norm_fixed_to_float.sv
// ============================================================================
// tb_i_norm_fixed_to_float : scoreboard bench with directed vectors
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i_norm_fixed_to_float;

  logic        CLK;
  logic        RST_FF;
  logic        Begin_FSM_FF;
  logic [31:0] FIXED;
  logic        ACK_FF;
  logic [31:0] RESULT;

  typedef struct {
    logic [31:0] fixed;
    logic [31:0] exp_result;
    int          lat;
    int          start;
  } txn_t;

  txn_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic ack_q    = 1'b0;

  i_norm_fixed_to_float #(.FRAC_BITS(26), .W(32)) dut (
    .CLK          (CLK),
    .RST_FF       (RST_FF),
    .Begin_FSM_FF (Begin_FSM_FF),
    .FIXED        (FIXED),
    .ACK_FF       (ACK_FF),
    .RESULT       (RESULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: on each rising ACK pop the oldest expectation. ACK that is
  // "high at cycle N" is sampled by edge N, so it is first visible at the
  // negedge following edge N-1.
  always @(negedge CLK) begin
    if (ACK_FF && !ack_q) begin
      if (q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        txn_t t;
        t = q.pop_front();
        check($sformatf("result_%08h", t.fixed), RESULT, t.exp_result);
        check($sformatf("latency_%08h", t.fixed), 32'(cyc - t.start + 1), 32'(t.lat));
      end
    end
    ack_q <= ACK_FF;
  end

  task automatic convert(input logic [31:0] fx, input logic [31:0] exp_res,
                         input int lat, input bit hold, input bit toggle);
    bit seen;
    txn_t t;
    @(negedge CLK);
    Begin_FSM_FF = 1'b1;
    FIXED        = fx;
    t.fixed = fx; t.exp_result = exp_res; t.lat = lat; t.start = cyc + 1;
    q.push_back(t);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK);
      if (toggle && i == 3) FIXED = ~fx;
      if (ACK_FF) seen = 1'b1;
    end
    if (!seen) begin
      check($sformatf("ack_timeout_%08h", fx), 32'd0, 32'd1);
      void'(q.pop_front());
    end
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge CLK);
        check("hold_ack", {31'd0, ACK_FF}, 32'd1);
        check("hold_result", RESULT, exp_res);
      end
    end
    Begin_FSM_FF = 1'b0;
    @(negedge CLK);
    check("ack_drop", {31'd0, ACK_FF}, 32'd0);
    check("result_held_idle", RESULT, exp_res);
  endtask

  initial begin
    RST_FF       = 1'b1;
    Begin_FSM_FF = 1'b0;
    FIXED        = 32'd0;
    @(negedge CLK);
    check("reset_ack", {31'd0, ACK_FF}, 32'd0);
    check("reset_result", RESULT, 32'd0);
    @(negedge CLK);
    RST_FF = 1'b0;

    convert(32'h04000000, 32'h3F800000,  9, 1'b0, 1'b0);
    convert(32'hFA000000, 32'hBFC00000,  9, 1'b0, 1'b0);
    convert(32'h80000000, 32'hC2000000,  4, 1'b0, 1'b0);
    convert(32'h00000000, 32'h00000000,  2, 1'b0, 1'b0);
    convert(32'h00000001, 32'h32800000, 35, 1'b0, 1'b0);
    convert(32'h01000001, 32'h3E800000, 11, 1'b0, 1'b0);
    convert(32'h01000003, 32'h3E800002, 11, 1'b0, 1'b0);
    convert(32'h7FFFFFFF, 32'h42000000,  5, 1'b1, 1'b0);
    convert(32'h04000000, 32'h3F800000,  9, 1'b0, 1'b1);
    convert(32'h7FFFFFFF, 32'h42000000,  5, 1'b0, 1'b0);

    // Abort a long conversion with an asynchronous reset mid-NORM.
    @(negedge CLK);
    Begin_FSM_FF = 1'b1;
    FIXED        = 32'h00000001;
    repeat (6) @(negedge CLK);
    #2 RST_FF = 1'b1;
    #1;
    check("async_rst_ack", {31'd0, ACK_FF}, 32'd0);
    check("async_rst_result", RESULT, 32'd0);
    Begin_FSM_FF = 1'b0;
    @(negedge CLK);
    RST_FF = 1'b0;
    repeat (40) @(negedge CLK);
    check("no_ack_after_abort", {31'd0, ACK_FF}, 32'd0);

    convert(32'h04000000, 32'h3F800000, 9, 1'b0, 1'b0);

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i_norm_fixed_to_float.md
Name: i_norm_fixed_to_float

Overview:
Multi-cycle converter from signed two's-complement fixed point to IEEE-754 single precision, the inverse of the float-to-fixed normalizer. It is started by a Begin/ACK handshake from the system FSM. Normalization uses an iterative left-shifter plus an exponent down-counter, not a barrel shifter. Rounding is round-to-nearest-even. The block feeds fixed-point estimator results back into the float datapath.

Parameters:
FRAC_BITS, 26, number of fractional bits in FIXED; legal range 0..31
W, 32, fixed-point input width; fixed at 32, no other value supported

Ports:
CLK  in  1  system clock, rising-edge
RST_FF  in  1  reset, asynchronous, active-high
Begin_FSM_FF  in  1  start request, level; sampled only in IDLE
FIXED  in  32  signed two's-complement value, value = FIXED * 2^-FRAC_BITS
ACK_FF  out  1  conversion done; high for the whole time the FSM is in DONE
RESULT  out  32  IEEE-754 single: sign[31], exponent[30:23], mantissa[22:0]

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; ACK_FF=0; RESULT=0; all internal registers cleared. A reset mid-conversion aborts it and produces no ACK.
- IDLE: if Begin_FSM_FF=1 at a clock edge, capture FIXED into an input register and go to LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle):
  - sign = bit31 of the captured value.
  - mag = |value| as a 32-bit unsigned; 0x80000000 maps to mag=0x80000000.
  - Exponent counter = 158 - FRAC_BITS.
  - If mag==0: RESULT=0x00000000 (+0, sign forced 0), go to DONE.
  - Otherwise go to NORM.
- NORM: if sh[31]==1, go to ROUND. Otherwise sh<<=1 and exp-=1. With k = leading zeros of mag, NORM lasts k+1 cycles.
- ROUND (1 cycle):
  - m = sh[30:8], guard = sh[7], sticky = OR of sh[6:0].
  - Round up when guard & (sticky | m[0]).
  - If m is all ones and rounds up: m=0, exp+=1.
  - RESULT = {sign, exp[7:0], m}, then go to DONE.
- DONE: ACK_FF=1. Stay while Begin_FSM_FF=1; go to IDLE when Begin_FSM_FF=0 (4-phase handshake).
- Latency: the edge that samples Begin in IDLE is cycle 0. ACK_FF rises at cycle k+4 for a nonzero input and at cycle 2 for a zero input. The worst case is k=31 (input 1), with ACK at cycle 35.
- Begin_FSM_FF and FIXED are ignored outside IDLE. FIXED may change after the capture edge.
- RESULT changes only in ROUND or in LOAD for the zero case. It holds its value through DONE and IDLE until the next conversion.
- Range: exponent field spans 96..159 for FRAC_BITS 0..31, so the block never produces denormals, infinities or NaN. Exp is 8 bits and cannot wrap.

Decomposition:
- Shared package holds:
  - State encoding, 3-bit: IDLE, LOAD, NORM, ROUND, DONE.
  - Constants FLOAT_BIAS=127, MANT_W=23, EXP_W=8.
  - EXP_INIT = 31 + FLOAT_BIAS - FRAC_BITS.
- One natural sub-module, fixed_to_float_normalizer, containing the shift register, exponent counter and round/pack logic, with enables driven by the top-level FSM. This mirrors the FSM/datapath split of the float-to-fixed side.

Test Plan (FRAC_BITS=26):
- FIXED=0x04000000 (1.0) -> RESULT=0x3F800000; k=5, so ACK_FF high at cycle 9.
- FIXED=0xFA000000 (-1.5) -> RESULT=0xBFC00000. FIXED=0x80000000 (-32.0) -> RESULT=0xC2000000 with ACK at cycle 4 (k=0).
- FIXED=0x00000000 -> RESULT=0x00000000 with ACK at cycle 2. FIXED=0x00000001 -> RESULT=0x32800000 with ACK at cycle 35.
- Rounding:
  - 0x01000001 -> 0x3E800000 (tie, round to even, down).
  - 0x01000003 -> 0x3E800002 (tie, odd, up).
  - 0x7FFFFFFF -> 0x42000000 (mantissa overflow bumps exponent).
- Handshake: hold Begin high 5 cycles past ACK -> ACK stays high, no restart. Drop Begin -> IDLE next cycle, ACK low. Toggle FIXED during NORM -> RESULT unaffected.
- Assert RST_FF asynchronously mid-NORM -> ACK_FF=0 and RESULT=0 immediately. A new Begin then converts 0x04000000 correctly to 0x3F800000.
